// File: rtl/frogger_lane_engine.sv
// -----------------------------------------------------------------------------
// frogger_lane_engine
//
// Multi-lane traffic engine for the Frogger game. Each lane owns a car that
// moves one pixel per step, either right (+X) or left (-X), and wraps around
// the visible width. Each lane has its own step divider. The lane period
// shrinks as the level rises, down to a floor, plus a fixed per-lane skew.
// A frog/car overlap in any lane raises a one-cycle hit pulse. The engine
// then freezes all traffic for a fixed number of cycles and resumes where it
// stopped.
//
// Ports
//   i_Clk        system clock
//   i_Reset      synchronous, active-high reset
//   i_Start      pulse, leaves IDLE and starts traffic
//   i_Level_Up   pulse, raises the level (RUN only, saturating)
//   i_Frog_X     frog left edge (pixels)
//   i_Frog_Y     frog top edge (pixels)
//   i_Lane_Y     lane k Y coordinate at bits [10k+9:10k]
//   i_Dir_Mask   bit k: 0 = lane k moves right, 1 = lane k moves left
//   o_Car_X      lane k car left edge at bits [10k+9:10k]
//   o_Hit        one-cycle collision pulse
//   o_Level      current level
//   o_State      0 = IDLE, 1 = RUN, 2 = FREEZE
//   o_Frozen     high while in FREEZE
// -----------------------------------------------------------------------------
module frogger_lane_engine #(
  parameter int NB_LANES       = 4,
  parameter int TILE_SIZE      = 32,
  parameter int H_VISIBLE_AREA = 640,
  parameter int BASE_PERIOD    = 250000,
  parameter int PERIOD_STEP    = 25000,
  parameter int MIN_PERIOD     = 50000,
  parameter int LANE_SKEW      = 10000,
  parameter int MAX_LEVEL      = 7,
  parameter int FREEZE_CYCLES  = 25000000
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  input  logic                     i_Start,
  input  logic                     i_Level_Up,
  input  logic [9:0]               i_Frog_X,
  input  logic [9:0]               i_Frog_Y,
  input  logic [NB_LANES*10-1:0]   i_Lane_Y,
  input  logic [NB_LANES-1:0]      i_Dir_Mask,
  output logic [NB_LANES*10-1:0]   o_Car_X,
  output logic                     o_Hit,
  output logic [2:0]               o_Level,
  output logic [1:0]               o_State,
  output logic                     o_Frozen
);

  // FSM encoding matches the o_State output encoding.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FREEZE = 2'd2;

  localparam logic [9:0]  X_MAX_C       = 10'(H_VISIBLE_AREA - 1);
  localparam logic [9:0]  X_LEFT_BASE_C = 10'(H_VISIBLE_AREA - TILE_SIZE);
  localparam logic [2:0]  LEVEL_MAX_C   = 3'(MAX_LEVEL);
  localparam logic [31:0] FREEZE_LAST_C = 32'(FREEZE_CYCLES - 1);
  localparam logic [10:0] TILE_C        = 11'(TILE_SIZE);

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Step period of one lane at a given level. The level-dependent part is
  // floored at MIN_PERIOD before the lane skew is added, so that higher lanes
  // stay slower than lane 0 even at the floor. The floor test is rearranged
  // into addition so that it cannot underflow when the reduction exceeds
  // BASE_PERIOD.
  function automatic logic [31:0] lane_period(input logic [2:0] lvl, input int lane);
    logic [31:0] red_v;
    logic [31:0] core_v;
    red_v = 32'(lvl) * 32'(PERIOD_STEP);
    if ((red_v + 32'(MIN_PERIOD)) >= 32'(BASE_PERIOD)) begin
      core_v = 32'(MIN_PERIOD);
    end else begin
      core_v = 32'(BASE_PERIOD) - red_v;
    end
    return core_v + (32'(lane) * 32'(LANE_SKEW));
  endfunction

  // One-pixel move with wrap-around at both edges of the visible area.
  function automatic logic [9:0] step_x(input logic [9:0] x, input logic dir_left);
    logic [9:0] nx;
    if (dir_left) begin
      if (x == 10'd0) begin
        nx = X_MAX_C;
      end else begin
        nx = x - 10'd1;
      end
    end else begin
      if (x == X_MAX_C) begin
        nx = 10'd0;
      end else begin
        nx = x + 10'd1;
      end
    end
    return nx;
  endfunction

  // Frog/car overlap for one lane. The distance is the unsigned absolute
  // difference, computed in 11 bits. Overlap across the wrap seam is
  // deliberately not detected.
  function automatic logic lane_overlap(input logic [9:0] fx, input logic [9:0] fy,
                                        input logic [9:0] cx, input logic [9:0] ly);
    logic [10:0] d;
    if (fx >= cx) begin
      d = {1'b0, fx} - {1'b0, cx};
    end else begin
      d = {1'b0, cx} - {1'b0, fx};
    end
    return (fy == ly) && (d < TILE_C);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]                    state_r,      state_s;
  logic [2:0]                    level_r,      level_s;
  logic                          hit_r,        hit_s;
  logic                          frozen_r,     frozen_s;
  logic [31:0]                   freeze_cnt_r, freeze_cnt_s;
  logic [NB_LANES-1:0][9:0]      car_x_r,      car_x_s;
  logic [NB_LANES-1:0][31:0]     div_r,        div_s;

  logic [NB_LANES-1:0][9:0]      base_x_s;
  logic [NB_LANES-1:0][31:0]     period_s;
  logic                          coll_s;

  // Per-lane base positions, current periods and the OR-ed collision flag.
  always_comb begin
    coll_s = 1'b0;
    for (int k = 0; k < NB_LANES; k++) begin
      base_x_s[k] = i_Dir_Mask[k] ? X_LEFT_BASE_C : 10'd0;
      period_s[k] = lane_period(level_r, k);
      coll_s      = coll_s | lane_overlap(i_Frog_X, i_Frog_Y, car_x_r[k], i_Lane_Y[10*k +: 10]);
    end
  end

  // Next-state logic: FSM, level, freeze counter, lane dividers and car X.
  always_comb begin
    state_s      = state_r;
    level_s      = level_r;
    hit_s        = 1'b0;
    freeze_cnt_s = freeze_cnt_r;
    car_x_s      = car_x_r;
    div_s        = div_r;

    case (state_r)
      ST_IDLE: begin
        // Cars sit at base positions that follow the direction mask live.
        car_x_s      = base_x_s;
        div_s        = {NB_LANES{32'd0}};
        freeze_cnt_s = 32'd0;
        if (i_Start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (coll_s) begin
          // A hit freezes traffic on this same edge: no step, and any
          // coincident level-up is dropped.
          state_s      = ST_FREEZE;
          hit_s        = 1'b1;
          freeze_cnt_s = 32'd0;
        end else if (i_Level_Up && (level_r < LEVEL_MAX_C)) begin
          // Restart every divider so that the new period is measured from
          // zero. A step that would have fallen on this edge is absorbed.
          level_s = level_r + 3'd1;
          div_s   = {NB_LANES{32'd0}};
        end else begin
          for (int k = 0; k < NB_LANES; k++) begin
            if (div_r[k] == (period_s[k] - 32'd1)) begin
              div_s[k]   = 32'd0;
              car_x_s[k] = step_x(car_x_r[k], i_Dir_Mask[k]);
            end else begin
              div_s[k]   = div_r[k] + 32'd1;
              car_x_s[k] = car_x_r[k];
            end
          end
        end
      end

      ST_FREEZE: begin
        // Cars and dividers hold their values; collisions are not evaluated.
        if (freeze_cnt_r == FREEZE_LAST_C) begin
          state_s      = ST_RUN;
          freeze_cnt_s = 32'd0;
        end else begin
          state_s      = ST_FREEZE;
          freeze_cnt_s = freeze_cnt_r + 32'd1;
        end
      end

      default: begin
        state_s      = ST_IDLE;
        car_x_s      = base_x_s;
        div_s        = {NB_LANES{32'd0}};
        freeze_cnt_s = 32'd0;
      end
    endcase

    frozen_s = (state_s == ST_FREEZE);
  end

  // State registers with synchronous reset back to IDLE at base positions.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_r      <= ST_IDLE;
      level_r      <= 3'd0;
      hit_r        <= 1'b0;
      frozen_r     <= 1'b0;
      freeze_cnt_r <= 32'd0;
      car_x_r      <= base_x_s;
      div_r        <= {NB_LANES{32'd0}};
    end else begin
      state_r      <= state_s;
      level_r      <= level_s;
      hit_r        <= hit_s;
      frozen_r     <= frozen_s;
      freeze_cnt_r <= freeze_cnt_s;
      car_x_r      <= car_x_s;
      div_r        <= div_s;
    end
  end

  assign o_Car_X  = car_x_r;
  assign o_Hit    = hit_r;
  assign o_Level  = level_r;
  assign o_State  = state_r;
  assign o_Frozen = frozen_r;

endmodule

// File: tb/tb_frogger_lane_engine.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for frogger_lane_engine, using small parameters: 2 lanes,
// tile 4, width 16, base period 4, step 1, floor 2, skew 1, freeze 8.
// The stimulus pushes hand-computed expectations, each tagged with the clock
// cycle it applies to. The monitor samples on the falling edge and pops the
// entries that are due.
// -----------------------------------------------------------------------------
module tb_frogger_lane_engine;

  localparam logic [4:0] M_CAR = 5'b00001;
  localparam logic [4:0] M_ST  = 5'b00010;
  localparam logic [4:0] M_LV  = 5'b00100;
  localparam logic [4:0] M_HIT = 5'b01000;
  localparam logic [4:0] M_FRZ = 5'b10000;
  localparam logic [4:0] M_ALL = 5'b11111;

  typedef struct {
    string      name;
    int         cyc;
    logic [4:0] mask;
    logic [9:0] x1;
    logic [9:0] x0;
    logic [1:0] st;
    logic [2:0] lv;
    logic       hit;
    logic       frz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        lvl_up;
  logic [9:0]  frog_x;
  logic [9:0]  frog_y;
  logic [19:0] lane_y;
  logic [1:0]  dir_mask;
  logic [19:0] car_x;
  logic        hit;
  logic [2:0]  level;
  logic [1:0]  state;
  logic        frozen;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  frogger_lane_engine #(
    .NB_LANES(2), .TILE_SIZE(4), .H_VISIBLE_AREA(16), .BASE_PERIOD(4),
    .PERIOD_STEP(1), .MIN_PERIOD(2), .LANE_SKEW(1), .MAX_LEVEL(7),
    .FREEZE_CYCLES(8)
  ) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Start(start), .i_Level_Up(lvl_up),
    .i_Frog_X(frog_x), .i_Frog_Y(frog_y), .i_Lane_Y(lane_y),
    .i_Dir_Mask(dir_mask), .o_Car_X(car_x), .o_Hit(hit), .o_Level(level),
    .o_State(state), .o_Frozen(frozen)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input string name, input int c, input logic [4:0] mask,
                          input int x1, input int x0, input int st, input int lv,
                          input int h, input int f);
    exp_t e;
    e.name = name; e.cyc = c; e.mask = mask;
    e.x1 = 10'(x1); e.x0 = 10'(x0); e.st = 2'(st); e.lv = 3'(lv);
    e.hit = 1'(h); e.frz = 1'(f);
    sb_q.push_back(e);
  endtask

  task automatic check_entry(input exp_t e);
    logic bad;
    bad = 1'b0;
    if (e.mask[0] && (car_x !== {e.x1, e.x0})) bad = 1'b1;
    if (e.mask[1] && (state !== e.st))         bad = 1'b1;
    if (e.mask[2] && (level !== e.lv))         bad = 1'b1;
    if (e.mask[3] && (hit !== e.hit))          bad = 1'b1;
    if (e.mask[4] && (frozen !== e.frz))       bad = 1'b1;
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL %s @cyc %0d mask=%b: got car={%0d,%0d} st=%0d lvl=%0d hit=%0d frz=%0d, want car={%0d,%0d} st=%0d lvl=%0d hit=%0d frz=%0d",
               e.name, cyc, e.mask, car_x[19:10], car_x[9:0], state, level, hit, frozen,
               e.x1, e.x0, e.st, e.lv, e.hit, e.frz);
    end
  endtask

  // Monitor: compare every expectation that is due this cycle; stale ones fail.
  always @(negedge clk) begin
    exp_t keep_q[$];
    keep_q = {};
    foreach (sb_q[i]) begin
      if (sb_q[i].cyc == cyc) begin
        check_entry(sb_q[i]);
      end else if (sb_q[i].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: expectation for cyc %0d never sampled (now %0d)", sb_q[i].name, sb_q[i].cyc, cyc);
      end else begin
        keep_q.push_back(sb_q[i]);
      end
    end
    sb_q = keep_q;
  end

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int e0;
    int r0;
    rst = 1'b1; start = 1'b0; lvl_up = 1'b0;
    frog_x = 10'd0; frog_y = 10'd50;
    lane_y = {10'd200, 10'd100};
    dir_mask = 2'b10;

    // Reset and IDLE base tracking
    wait_until(2);
    rst = 1'b0;
    push_exp("reset", 2, M_ALL, 12, 0, 0, 0, 0, 0);
    dir_mask = 2'b01;
    push_exp("idle_dir_swap", 3, M_CAR | M_ST, 0, 12, 0, 0, 0, 0);
    wait_until(3);
    dir_mask = 2'b10;
    push_exp("idle_dir_back", 4, M_CAR | M_ST, 12, 0, 0, 0, 0, 0);
    wait_until(4);
    start = 1'b1;

    // RUN entry edge is cycle e0
    e0 = 5;
    wait_until(e0);
    start = 1'b0;
    push_exp("run_entry",   e0,      M_ALL,        12, 0, 1, 0, 0, 0);
    push_exp("pre_step",    e0 + 3,  M_CAR | M_ST, 12, 0, 1, 0, 0, 0);
    push_exp("l0_step1",    e0 + 4,  M_CAR | M_ST, 12, 1, 1, 0, 0, 0);
    push_exp("l1_step1",    e0 + 5,  M_CAR | M_ST, 11, 1, 1, 0, 0, 0);
    push_exp("l0_step2",    e0 + 8,  M_CAR | M_ST, 11, 2, 1, 0, 0, 0);
    push_exp("l1_step2",    e0 + 10, M_CAR | M_ST, 10, 2, 1, 0, 0, 0);
    push_exp("pre_wrap",    e0 + 59, M_CAR,         1, 14, 1, 0, 0, 0);
    push_exp("at_edges",    e0 + 60, M_CAR,         0, 15, 1, 0, 0, 0);
    push_exp("l0_wrap",     e0 + 64, M_CAR,         0, 0, 1, 0, 0, 0);
    push_exp("l1_wrap",     e0 + 65, M_CAR,        15, 0, 1, 0, 0, 0);

    // Collision with lane 0 (car at 0, frog at 3)
    wait_until(e0 + 66);
    frog_x = 10'd3; frog_y = 10'd100;
    push_exp("hit_pulse",   e0 + 67, M_ALL, 15, 0, 2, 0, 1, 0 + 1);
    wait_until(e0 + 67);
    frog_x = 10'd0; frog_y = 10'd50;
    push_exp("hit_drop",    e0 + 68, M_ALL, 15, 0, 2, 0, 0, 1);
    push_exp("freeze_mid",  e0 + 71, M_ALL, 15, 0, 2, 0, 0, 1);
    push_exp("freeze_last", e0 + 74, M_ALL, 15, 0, 2, 0, 0, 1);
    push_exp("resume",      e0 + 75, M_ALL, 15, 0, 1, 0, 0, 0);
    push_exp("resume_hold", e0 + 76, M_CAR | M_ST, 15, 0, 1, 0, 0, 0);
    push_exp("resume_l0",   e0 + 77, M_CAR | M_ST, 15, 1, 1, 0, 0, 0);
    push_exp("resume_l0b",  e0 + 78, M_CAR | M_ST, 15, 1, 1, 0, 0, 0);
    push_exp("resume_l1",   e0 + 79, M_CAR | M_ST, 14, 1, 1, 0, 0, 0);

    // Level-ups: lane0 period 3, 2, 2 (floor)
    wait_until(e0 + 81);
    push_exp("lv0_pos",     e0 + 81, M_CAR, 14, 2, 1, 0, 0, 0);
    lvl_up = 1'b1;
    wait_until(e0 + 82);
    lvl_up = 1'b0;
    push_exp("lv1",         e0 + 82, M_CAR | M_ST | M_LV, 14, 2, 1, 1, 0, 0);
    push_exp("lv1_hold",    e0 + 84, M_CAR, 14, 2, 1, 1, 0, 0);
    push_exp("lv1_l0",      e0 + 85, M_CAR, 14, 3, 1, 1, 0, 0);
    push_exp("lv1_l1",      e0 + 86, M_CAR, 13, 3, 1, 1, 0, 0);
    wait_until(e0 + 86);
    lvl_up = 1'b1;
    wait_until(e0 + 87);
    lvl_up = 1'b0;
    push_exp("lv2",         e0 + 87, M_CAR | M_LV, 13, 3, 1, 2, 0, 0);
    push_exp("lv2_hold",    e0 + 88, M_CAR, 13, 3, 1, 2, 0, 0);
    push_exp("lv2_l0a",     e0 + 89, M_CAR, 13, 4, 1, 2, 0, 0);
    push_exp("lv2_l1",      e0 + 90, M_CAR, 12, 4, 1, 2, 0, 0);
    push_exp("lv2_l0b",     e0 + 91, M_CAR, 12, 5, 1, 2, 0, 0);
    wait_until(e0 + 91);
    lvl_up = 1'b1;
    wait_until(e0 + 92);
    lvl_up = 1'b0;
    push_exp("lv3",         e0 + 92, M_CAR | M_LV, 12, 5, 1, 3, 0, 0);
    push_exp("lv3_hold",    e0 + 93, M_CAR, 12, 5, 1, 3, 0, 0);
    push_exp("lv3_floor",   e0 + 94, M_CAR, 12, 6, 1, 3, 0, 0);
    push_exp("lv3_l1",      e0 + 95, M_CAR, 11, 6, 1, 3, 0, 0);

    // Ten more level-ups saturate at 7
    push_exp("lv4",         e0 + 97,  M_ST | M_LV, 0, 0, 1, 4, 0, 0);
    push_exp("lv_sat",      e0 + 116, M_ST | M_LV | M_HIT | M_FRZ, 0, 0, 1, 7, 0, 0);
    for (int i = 0; i < 10; i++) begin
      wait_until(e0 + 96 + 2 * i);
      lvl_up = 1'b1;
      wait_until(e0 + 97 + 2 * i);
      lvl_up = 1'b0;
    end

    // Reset mid-RUN, restart, hit coincident with level-up, reset mid-FREEZE
    r0 = e0 + 117;
    wait_until(r0);
    rst = 1'b1;
    wait_until(r0 + 1);
    rst = 1'b0;
    start = 1'b1;
    push_exp("rst_run",     r0 + 1, M_ALL, 12, 0, 0, 0, 0, 0);
    wait_until(r0 + 2);
    start = 1'b0;
    frog_x = 10'd3; frog_y = 10'd100;
    lvl_up = 1'b1;
    push_exp("rerun",       r0 + 2, M_CAR | M_ST | M_LV, 12, 0, 1, 0, 0, 0);
    wait_until(r0 + 3);
    lvl_up = 1'b0;
    frog_x = 10'd0; frog_y = 10'd50;
    push_exp("hit_vs_lvup", r0 + 3, M_ALL, 12, 0, 2, 0, 1, 1);
    push_exp("frz_c1",      r0 + 4, M_ST | M_LV | M_HIT | M_FRZ, 0, 0, 2, 0, 0, 1);
    push_exp("frz_c3",      r0 + 6, M_ST | M_FRZ, 0, 0, 2, 0, 0, 1);
    wait_until(r0 + 6);
    rst = 1'b1;
    wait_until(r0 + 7);
    rst = 1'b0;
    push_exp("rst_freeze",  r0 + 7, M_ALL, 12, 0, 0, 0, 0, 0);
    push_exp("idle_after",  r0 + 9, M_ALL, 12, 0, 0, 0, 0, 0);

    wait_until(r0 + 12);
    foreach (sb_q[i]) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: expectation for cyc %0d left unchecked", sb_q[i].name, sb_q[i].cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so a stuck run still terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cyc %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
